phy_rx_deser_lanes: RTL and testbench

Parametrised single-clock PHY receiver. A serial bit stream arrives MSB-first at one bit per clock and is deserialised into WIDTH-bit words. The block aligns to a comma (COM) symbol, declares lock after LOCK_COUNT consecutive aligned COMs, drops IDLE fill, and distributes data words round-robin over LANES output lanes. It also drives a serial status echo (COM while unlocked, IDLE while locked) back toward the transmitter side.

---
 rtl/phy_rx_deser_lanes.sv | 167 ++++++++++++++++
 tb/tb_phy_rx_deser_lanes.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deser_lanes.sv
// Serial PHY receiver: comma alignment, lock tracking, IDLE drop and
// round-robin distribution of data words over LANES output lanes, plus a
// serial status echo (COM while unlocked, IDLE while locked).
module phy_rx_deser_lanes #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      LANES       = 4,
    parameter logic [WIDTH-1:0] COM         = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE        = 8'h7C,
    parameter int unsigned      LOCK_COUNT  = 4,
    parameter int unsigned      COM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   active,
    output logic                   serial_out
);

    localparam int unsigned BIT_W  = $clog2(WIDTH);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned COM_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GAP_W  = (COM_TIMEOUT > 0) ? $clog2(COM_TIMEOUT + 1) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(LANES - 1);
    localparam logic [COM_W-1:0]  COM_GOAL   = COM_W'(LOCK_COUNT);
    localparam logic [GAP_W-1:0]  GAP_LIMIT  = GAP_W'(COM_TIMEOUT);
    localparam bit                TIMEOUT_EN = (COM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } state_t;

    state_t             state, stateNext;
    logic [WIDTH-1:0]   sh, nxt, txSh;
    logic [BIT_W-1:0]   bitCnt, bitCntNext, txCnt;
    logic [COM_W-1:0]   comCnt, comCntNext;
    logic [GAP_W-1:0]   gapCnt, gapCntNext;
    logic [LANE_W-1:0]  lanePtr, lanePtrNext;
    logic               boundary;
    logic               forward;

    // Next-state, counter updates and forward decision for the current word.
    always_comb begin
        nxt         = {sh[WIDTH-2:0], serial_in};
        boundary    = (bitCnt == BIT_LAST);
        stateNext   = state;
        bitCntNext  = boundary ? '0 : bitCnt + 1'b1;
        comCntNext  = comCnt;
        gapCntNext  = gapCnt;
        lanePtrNext = lanePtr;
        forward     = 1'b0;

        case (state)
            SEARCH: begin
                bitCntNext = '0;
                if (nxt == COM) begin
                    comCntNext = COM_W'(1);
                    if (LOCK_COUNT == 1) begin
                        stateNext   = LOCKED;
                        lanePtrNext = '0;
                        gapCntNext  = '0;
                    end else begin
                        stateNext = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (nxt == COM) begin
                        comCntNext = comCnt + 1'b1;
                        if (comCntNext == COM_GOAL) begin
                            stateNext   = LOCKED;
                            lanePtrNext = '0;
                            gapCntNext  = '0;
                        end
                    end else begin
                        stateNext  = SEARCH;
                        comCntNext = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (nxt == COM) begin
                        lanePtrNext = '0;
                        gapCntNext  = '0;
                    end else begin
                        forward = (nxt != IDLE);
                        if (forward) begin
                            lanePtrNext = (lanePtr == LANE_LAST) ? '0 : lanePtr + 1'b1;
                        end
                        // A data word that trips the timeout is still forwarded.
                        if (TIMEOUT_EN) begin
                            gapCntNext = gapCnt + 1'b1;
                            if (gapCntNext == GAP_LIMIT) begin
                                stateNext   = SEARCH;
                                lanePtrNext = '0;
                                comCntNext  = '0;
                            end
                        end
                    end
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

    // Receive state, alignment counters and the input shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SEARCH;
            sh      <= '0;
            bitCnt  <= '0;
            comCnt  <= '0;
            gapCnt  <= '0;
            lanePtr <= '0;
        end else begin
            state   <= stateNext;
            sh      <= nxt;
            bitCnt  <= bitCntNext;
            comCnt  <= comCntNext;
            gapCnt  <= gapCntNext;
            lanePtr <= lanePtrNext;
        end
    end

    // Lane data/valid registers and the lock indicator.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= '0;
            active    <= 1'b0;
        end else begin
            valid_out <= '0;
            for (int k = 0; k < LANES; k++) begin
                if (forward && (lanePtr == LANE_W'(k))) begin
                    data_out[k*WIDTH +: WIDTH] <= nxt;
                    valid_out[k]               <= 1'b1;
                end
            end
            active <= (stateNext == LOCKED);
        end
    end

    // Status echo: pattern chosen only at symbol start so symbols are never split.
    always_ff @(posedge clk) begin
        if (reset) begin
            txCnt      <= '0;
            txSh       <= '0;
            serial_out <= 1'b0;
        end else begin
            serial_out <= txSh[WIDTH-1];
            txCnt      <= (txCnt == BIT_LAST) ? '0 : txCnt + 1'b1;
            if (txCnt == '0) begin
                txSh <= active ? IDLE : COM;
            end else begin
                txSh <= {txSh[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_deser_lanes.sv
// Bench for phy_rx_deser_lanes: two instances (8-bit/4-lane and
// 10-bit/2-lane), a word-level reference model and scenario tasks.
module tb_phy_rx_deser_lanes;

    localparam int unsigned WA  = 8;
    localparam int unsigned LA  = 4;
    localparam int unsigned WB  = 10;
    localparam int unsigned LB  = 2;
    localparam int unsigned TWA = WA*LA + LA + 2;
    localparam int unsigned TWB = WB*LB + LB + 2;
    localparam int LOCKN = 4;
    localparam int TOUT  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, sinA, sinB;
    logic [WA*LA-1:0] dataA;
    logic [LA-1:0]    validA;
    logic             activeA, soutA;
    logic [WB*LB-1:0] dataB;
    logic [LB-1:0]    validB;
    logic             activeB, soutB;

    phy_rx_deser_lanes dutA (
        .clk(clk), .reset(reset), .serial_in(sinA),
        .data_out(dataA), .valid_out(validA), .active(activeA), .serial_out(soutA)
    );

    phy_rx_deser_lanes #(
        .WIDTH(10), .LANES(2), .COM(10'h17C), .IDLE(10'h283),
        .LOCK_COUNT(4), .COM_TIMEOUT(16)
    ) dutB (
        .clk(clk), .reset(reset), .serial_in(sinB),
        .data_out(dataB), .valid_out(validB), .active(activeB), .serial_out(soutB)
    );

    int nCmp = 0;
    int nBad = 0;

    // reference model state, index 0 = dutA, 1 = dutB
    int cW[2]    = '{8, 10};
    int cL[2]    = '{4, 2};
    int cCom[2]  = '{'hBC, 'h17C};
    int cIdle[2] = '{'h7C, 'h283};
    int mWin[2], mSince[2], mRun[2], mPtr[2], mGap[2], mVal[2], mEdge[2], mPat[2];
    int mLane[2][4];
    bit mSearch[2], mLocked[2], mSer[2];

    bit bitsA[$], bitsB[$];
    logic [TWA-1:0] trA[$], exA[$];
    logic [TWB-1:0] trB[$], exB[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mWin[i] = 0; mSince[i] = 0; mRun[i] = 0; mPtr[i] = 0; mGap[i] = 0;
            mVal[i] = -1; mEdge[i] = 0; mPat[i] = 0;
            mSearch[i] = 1'b1; mLocked[i] = 1'b0; mSer[i] = 1'b0;
            for (int k = 0; k < 4; k++) mLane[i][k] = 0;
        end
    endtask

    // One received bit: sliding window, word framing by bit count, lane routing.
    task automatic model_step(int i, bit b);
        bit wasLocked;
        int w, word;
        w = cW[i];
        wasLocked = mLocked[i];
        mVal[i] = -1;
        mWin[i] = ((mWin[i] << 1) | int'(b)) & ((1 << w) - 1);
        if (mSearch[i]) begin
            if (mWin[i] == cCom[i]) begin
                mSearch[i] = 1'b0; mSince[i] = 0; mRun[i] = 1;
                if (LOCKN == 1) begin mLocked[i] = 1'b1; mPtr[i] = 0; mGap[i] = 0; end
            end
        end else begin
            mSince[i]++;
            if (mSince[i] % w == 0) begin
                word = mWin[i];
                if (!mLocked[i]) begin
                    if (word == cCom[i]) begin
                        mRun[i]++;
                        if (mRun[i] == LOCKN) begin mLocked[i] = 1'b1; mPtr[i] = 0; mGap[i] = 0; end
                    end else begin
                        mSearch[i] = 1'b1; mRun[i] = 0;
                    end
                end else if (word == cCom[i]) begin
                    mPtr[i] = 0; mGap[i] = 0;
                end else begin
                    if (word != cIdle[i]) begin
                        mLane[i][mPtr[i]] = word;
                        mVal[i] = mPtr[i];
                        mPtr[i] = (mPtr[i] + 1) % cL[i];
                    end
                    mGap[i]++;
                    if (TOUT != 0 && mGap[i] == TOUT) begin
                        mLocked[i] = 1'b0; mSearch[i] = 1'b1; mPtr[i] = 0; mRun[i] = 0;
                    end
                end
            end
        end
        mEdge[i]++;
        mSer[i] = (mEdge[i] >= 2) ? 1'((mPat[i] >> (w - 1 - ((mEdge[i] - 2) % w))) & 1) : 1'b0;
        if ((mEdge[i] - 1) % w == 0) mPat[i] = wasLocked ? cIdle[i] : cCom[i];
    endtask

    function automatic logic [WA*LA-1:0] expDataA();
        logic [WA*LA-1:0] r;
        for (int k = 0; k < LA; k++) r[k*WA +: WA] = WA'(mLane[0][k]);
        return r;
    endfunction

    function automatic logic [WB*LB-1:0] expDataB();
        logic [WB*LB-1:0] r;
        for (int k = 0; k < LB; k++) r[k*WB +: WB] = WB'(mLane[1][k]);
        return r;
    endfunction

    function automatic logic [LA-1:0] expValidA();
        return (mVal[0] >= 0) ? LA'(1 << mVal[0]) : '0;
    endfunction

    function automatic logic [LB-1:0] expValidB();
        return (mVal[1] >= 0) ? LB'(1 << mVal[1]) : '0;
    endfunction

    task automatic drive(bit a, bit b, bit rst);
        sinA = a; sinB = b; reset = rst;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0, a);
            model_step(1, b);
        end
        #1;
    endtask

    task automatic addA(int word);
        for (int b = WA - 1; b >= 0; b--) bitsA.push_back(1'((word >> b) & 1));
    endtask

    task automatic addB(int word);
        for (int b = WB - 1; b >= 0; b--) bitsB.push_back(1'((word >> b) & 1));
    endtask

    // Plays the queued bits (random filler where a queue is short) and records
    // DUT outputs and model expectations per cycle.
    task automatic run_stream();
        int n;
        bit a, b;
        n = (bitsA.size() > bitsB.size()) ? bitsA.size() : bitsB.size();
        trA.delete(); exA.delete(); trB.delete(); exB.delete();
        for (int j = 0; j < n; j++) begin
            a = (j < bitsA.size()) ? bitsA[j] : 1'($urandom & 1);
            b = (j < bitsB.size()) ? bitsB[j] : 1'($urandom & 1);
            drive(a, b, 1'b0);
            trA.push_back({dataA, validA, activeA, soutA});
            exA.push_back({expDataA(), expValidA(), mLocked[0], mSer[0]});
            trB.push_back({dataB, validB, activeB, soutB});
            exB.push_back({expDataB(), expValidB(), mLocked[1], mSer[1]});
        end
        bitsA.delete(); bitsB.delete();
    endtask

    function automatic int rndWordA();
        int w;
        do w = $urandom_range(255, 0); while (w == 'hBC);
        return w;
    endfunction

    function automatic int rndWordB();
        int w;
        do w = $urandom_range(1023, 0); while (w == 'h17C || w == 'h283);
        return w;
    endfunction

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        nCmp++;
        if ({dataA, validA, activeA, soutA} !== '0) begin
            nBad++; $display("FAIL reset_A got %h exp 0", {dataA, validA, activeA, soutA});
        end
        nCmp++;
        if ({dataB, validB, activeB, soutB} !== '0) begin
            nBad++; $display("FAIL reset_B got %h exp 0", {dataB, validB, activeB, soutB});
        end
    endtask

    task automatic test_basic();
        logic [TWA-1:0] e;
        int np;
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) addA('hBC);
        for (int k = 1; k <= 5; k++) addA(k);
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL basic_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[30][1] !== 1'b0 || trA[31][1] !== 1'b1) begin
            nBad++; $display("FAIL basic_lock got %b%b exp 01", trA[30][1], trA[31][1]);
        end
        np = 0;
        for (int j = 0; j < trA.size(); j++) begin
            e = trA[j];
            if (e[5:2] != 4'b0) begin
                nCmp++;
                if (j != 39 + 8*np || e[5:2] !== 4'(1 << (np % 4)) || e[6 + (np % 4)*8 +: 8] !== 8'(np + 1)) begin
                    nBad++; $display("FAIL basic_pulse cyc=%0d got v=%b d=%h exp cyc=%0d word=%0d", j, e[5:2], e[37:6], 39 + 8*np, np + 1);
                end
                np++;
            end
        end
        nCmp++;
        if (np != 5) begin nBad++; $display("FAIL basic_pulse_count got %0d exp 5", np); end
        e = trA[trA.size() - 1];
        nCmp++;
        if (e[37:6] !== 32'h04030205) begin nBad++; $display("FAIL basic_lanes got %h exp 04030205", e[37:6]); end
    endtask

    task automatic test_offset();
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) bitsA.push_back(1'($urandom & 1));
        repeat (4) addA('hBC);
        addA('h11); addA('h22);
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL offset_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[33][1] !== 1'b0 || trA[34][1] !== 1'b1) begin
            nBad++; $display("FAIL offset_lock got %b%b exp 01", trA[33][1], trA[34][1]);
        end
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) bitsA.push_back(1'($urandom & 1));
        repeat (3) addA('hBC);
        addA('hAA);
        repeat (4) addA('hBC);
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL broken_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[34][1] !== 1'b0 || trA[58][1] !== 1'b0 || trA[65][1] !== 1'b0 || trA[66][1] !== 1'b1) begin
            nBad++; $display("FAIL broken_lock got %b%b%b%b exp 0001", trA[34][1], trA[58][1], trA[65][1], trA[66][1]);
        end
    endtask

    task automatic test_idle_com();
        logic [TWA-1:0] e;
        int np;
        int expJ[3]    = '{39, 63, 79};
        int expLane[3] = '{0, 1, 0};
        int expVal[3]  = '{'h11, 'h22, 'h33};
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) addA('hBC);
        addA('h11); addA('h7C); addA('h7C); addA('h22); addA('hBC); addA('h33);
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL idle_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        np = 0;
        for (int j = 0; j < trA.size(); j++) begin
            e = trA[j];
            if (e[5:2] != 4'b0) begin
                nCmp++;
                if (np >= 3) begin
                    nBad++; $display("FAIL idle_extra_pulse cyc=%0d got v=%b exp none", j, e[5:2]);
                end else if (j != expJ[np] || e[5:2] !== 4'(1 << expLane[np]) ||
                             e[6 + expLane[np]*8 +: 8] !== 8'(expVal[np])) begin
                    nBad++; $display("FAIL idle_pulse cyc=%0d got v=%b d=%h exp cyc=%0d lane=%0d val=%h", j, e[5:2], e[37:6], expJ[np], expLane[np], expVal[np]);
                end
                np++;
            end
        end
        nCmp++;
        if (np != 3) begin nBad++; $display("FAIL idle_pulse_count got %0d exp 3", np); end
    endtask

    task automatic test_timeout();
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) addA('hBC);
        repeat (16) addA(rndWordA());
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL timeout_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[158][1] !== 1'b1 || trA[159][1] !== 1'b0) begin
            nBad++; $display("FAIL timeout_drop got %b%b exp 10", trA[158][1], trA[159][1]);
        end
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) addA('hBC);
        repeat (15) addA(rndWordA());
        addA('hBC);
        repeat (4) addA(rndWordA());
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL keep_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[159][1] !== 1'b1 || trA[trA.size() - 1][1] !== 1'b1) begin
            nBad++; $display("FAIL timeout_keep got %b%b exp 11", trA[159][1], trA[trA.size() - 1][1]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) addA('hBC);
        addA('h55);
        bitsA.push_back(1'b0); bitsA.push_back(1'b1); bitsA.push_back(1'b1);
        run_stream();
        nCmp++;
        if (trA[trA.size() - 1][1] !== 1'b1) begin nBad++; $display("FAIL midrst_prelock got 0 exp 1"); end
        drive(1'b0, 1'b1, 1'b1);
        nCmp++;
        if ({dataA, validA, activeA, soutA} !== '0) begin
            nBad++; $display("FAIL midrst_A got %h exp 0", {dataA, validA, activeA, soutA});
        end
        repeat (4) addA('hBC);
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL relock_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
        end
        nCmp++;
        if (trA[23][1] !== 1'b0 || trA[31][1] !== 1'b1) begin
            nBad++; $display("FAIL relock got %b%b exp 01", trA[23][1], trA[31][1]);
        end
    endtask

    task automatic test_wide();
        logic [TWB-1:0] f;
        int words[$];
        int exp[$];
        int np, sw;
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) words.push_back((k == 3) ? 'h283 : rndWordB());
        repeat (4) addB('h17C);
        foreach (words[k]) begin
            addB(words[k]);
            if (words[k] != 'h283) exp.push_back(words[k]);
        end
        run_stream();
        for (int j = 0; j < trB.size(); j++) begin
            nCmp++;
            if (trB[j] !== exB[j]) begin nBad++; $display("FAIL wide_B cyc=%0d got %h exp %h", j, trB[j], exB[j]); end
        end
        nCmp++;
        if (trB[38][1] !== 1'b0 || trB[39][1] !== 1'b1) begin
            nBad++; $display("FAIL wide_lock got %b%b exp 01", trB[38][1], trB[39][1]);
        end
        np = 0;
        for (int j = 0; j < trB.size(); j++) begin
            f = trB[j];
            if (f[3:2] != 2'b0) begin
                nCmp++;
                if (np >= exp.size()) begin
                    nBad++; $display("FAIL wide_extra_pulse cyc=%0d got v=%b exp none", j, f[3:2]);
                end else if (f[3:2] !== 2'(1 << (np % 2)) || f[4 + (np % 2)*10 +: 10] !== 10'(exp[np])) begin
                    nBad++; $display("FAIL wide_pulse cyc=%0d got v=%b d=%h exp lane=%0d val=%h", j, f[3:2], f[23:4], np % 2, exp[np]);
                end
                np++;
            end
        end
        nCmp++;
        if (np != exp.size()) begin nBad++; $display("FAIL wide_pulse_count got %0d exp %0d", np, exp.size()); end
        sw = 0;
        for (int j = 1; j <= 10; j++) begin f = trB[j]; sw = (sw << 1) | int'(f[0]); end
        nCmp++;
        if (10'(sw) !== 10'h17C) begin nBad++; $display("FAIL wide_echo_first got %h exp 17c", 10'(sw)); end
        sw = 0;
        for (int j = 31; j <= 40; j++) begin f = trB[j]; sw = (sw << 1) | int'(f[0]); end
        nCmp++;
        if (10'(sw) !== 10'h17C) begin nBad++; $display("FAIL wide_echo_prelock got %h exp 17c", 10'(sw)); end
        sw = 0;
        for (int j = 41; j <= 50; j++) begin f = trB[j]; sw = (sw << 1) | int'(f[0]); end
        nCmp++;
        if (10'(sw) !== 10'h283) begin nBad++; $display("FAIL wide_echo_locked got %h exp 283", 10'(sw)); end
    endtask

    task automatic test_random();
        int r;
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) begin addA('hBC); addB('h17C); end
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(99, 0);
            if (r < 8) addA('hBC);
            else if (r < 20) addA('h7C);
            else if (r < 24) repeat ($urandom_range(3, 1)) bitsA.push_back(1'($urandom & 1));
            else addA(rndWordA());
            r = $urandom_range(99, 0);
            if (r < 8) addB('h17C);
            else if (r < 20) addB('h283);
            else if (r < 24) repeat ($urandom_range(3, 1)) bitsB.push_back(1'($urandom & 1));
            else addB(rndWordB());
        end
        run_stream();
        for (int j = 0; j < trA.size(); j++) begin
            nCmp++;
            if (trA[j] !== exA[j]) begin nBad++; $display("FAIL random_A cyc=%0d got %h exp %h", j, trA[j], exA[j]); end
            nCmp++;
            if (trB[j] !== exB[j]) begin nBad++; $display("FAIL random_B cyc=%0d got %h exp %h", j, trB[j], exB[j]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        sinA  = 1'b0;
        sinB  = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_offset();
        test_idle_com();
        test_timeout();
        test_reset_mid();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
